// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave: word RAM behind a SETUP/ACCESS handshake with
// byte strobes, a fixed number of wait states and an error response for
// out-of-range or misaligned accesses.
module apb4_mem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = ADDR_WIDTH - AL;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [MW-1:0]         widx_q;
  logic                  pwrite_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          setup, done, misal, err_d, we;
  logic [IW-1:0] idx;

  assign setup = (state == IDLE) && psel && !penable;
  assign idx   = paddr[ADDR_WIDTH-1:AL];

  // Low address bits must be zero for a word access; byte-wide buses have none.
  if (AL > 0) begin : g_align
    assign misal = |paddr[AL-1:0];
  end else begin : g_noalign
    assign misal = 1'b0;
  end

  // Widen by one bit so DEPTH == 2**IW compares correctly.
  assign err_d = ({1'b0, idx} >= (IW+1)'(DEPTH)) || misal;

  // Responses come from registers only, never from live bus inputs.
  assign pready  = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !pwrite_q && !err_q) ? prdata_q : '0;

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; dropping psel mid-ACCESS aborts without a response.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0 && penable) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at SETUP and prefetch read data; count down wait states.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt      <= '0;
      widx_q   <= '0;
      pwrite_q <= 1'b0;
      strb_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else if (setup) begin
      widx_q   <= idx[MW-1:0];
      pwrite_q <= pwrite;
      strb_q   <= pstrb;
      wdata_q  <= pwdata;
      err_q    <= err_d;
      cnt      <= 4'(WAIT_STATES);
      if (!pwrite && !err_d) prdata_q <= mem[idx[MW-1:0]];
    end else if (state == ACCESS && psel && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Commit only on a completed, error-free write; reset at the same edge wins.
  assign we = done && pwrite_q && !err_q && !rst;

  // Byte-lane RAM write.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NB; i++)
      if (we && strb_q[i]) mem[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: three slave builds on one shared bus (WS=0, WS=3 with an
// 11-bit address, WS=2), each selected by its own psel bit.
module tb_apb4_mem_slave;
  logic             pclk = 1'b0;
  logic             rst;
  logic [10:0]      paddr;
  logic [2:0]       psel;
  logic             penable, pwrite;
  logic [31:0]      pwdata;
  logic [3:0]       pstrb;
  logic [2:0][31:0] rdat;
  logic [2:0]       rdy, err;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        er;
  int          n;
  logic        seen;

  always #5 pclk = ~pclk;

  apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .rst(rst), .paddr(paddr[9:0]), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdat[0]),
    .pready(rdy[0]), .pslverr(err[0]));

  apb4_mem_slave #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u1 (
    .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdat[1]),
    .pready(rdy[1]), .pslverr(err[1]));

  apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u2 (
    .pclk(pclk), .rst(rst), .paddr(paddr[9:0]), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdat[2]),
    .pready(rdy[2]), .pslverr(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer starting at posedge+1; returns at posedge+1 after
  // completion so calls chain with no idle cycle. Bus is scrambled during
  // ACCESS to show the slave uses the SETUP-phase values.
  task automatic xfer(input int d, input logic wr, input logic [10:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rdo, output logic ero, output int cyc);
    logic ok;
    ok = 1'b0; rdo = '0; ero = 1'bx;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = ~a; pwdata = ~wd;
    cyc = 1;
    repeat (30) begin
      cyc++;
      @(negedge pclk);
      if (rdy[d]) begin
        rdo = rdat[d]; ero = err[d]; ok = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
    if (ok) begin
      @(posedge pclk); #1;
    end else begin
      cyc = 999;
    end
    psel = '0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    @(posedge pclk);
    @(negedge pclk);
    chk("reset_pready",  {29'd0, rdy}, 32'd0);
    chk("reset_pslverr", {29'd0, err}, 32'd0);
    chk("reset_prdata0", rdat[0], 32'd0);
    chk("reset_prdata1", rdat[1], 32'd0);
    @(posedge pclk); #1;
    rst = 1'b0;
    @(posedge pclk); #1;

    // Basic WS=0 write/read
    xfer(0, 1, 11'h010, 32'hDEADBEEF, 4'hF, rd, er, n);
    chk("ws0_wr_cycles", n, 2);
    chk("ws0_wr_err", {31'd0, er}, 0);
    xfer(0, 0, 11'h010, 32'h0, 4'h0, rd, er, n);
    chk("ws0_rd_cycles", n, 2);
    chk("ws0_rd_data", rd, 32'hDEADBEEF);
    chk("ws0_rd_err", {31'd0, er}, 0);

    // Byte strobes
    xfer(0, 1, 11'h020, 32'h11223344, 4'hF, rd, er, n);
    xfer(0, 1, 11'h020, 32'hAABBCCDD, 4'h5, rd, er, n);
    xfer(0, 0, 11'h020, 32'h0, 4'h0, rd, er, n);
    chk("strb_merge", rd, 32'h11BB33DD);
    xfer(0, 1, 11'h020, 32'hFFFFFFFF, 4'h0, rd, er, n);
    chk("strb0_err", {31'd0, er}, 0);
    xfer(0, 0, 11'h020, 32'h0, 4'h0, rd, er, n);
    chk("strb0_noop", rd, 32'h11BB33DD);

    // Misaligned write must error and leave mem[4] intact
    xfer(0, 1, 11'h013, 32'h0, 4'hF, rd, er, n);
    chk("misal_err", {31'd0, er}, 1);
    chk("misal_cycles", n, 2);
    xfer(0, 0, 11'h010, 32'h0, 4'h0, rd, er, n);
    chk("misal_mem4", rd, 32'hDEADBEEF);

    // Back-to-back, no idle cycles between transfers
    xfer(0, 1, 11'h040, 32'hCAFE0001, 4'hF, rd, er, n);
    chk("b2b_w0_cycles", n, 2);
    xfer(0, 1, 11'h044, 32'h12345678, 4'hF, rd, er, n);
    chk("b2b_w1_cycles", n, 2);
    xfer(0, 0, 11'h040, 32'h0, 4'h0, rd, er, n);
    chk("b2b_r0", rd, 32'hCAFE0001);
    xfer(0, 0, 11'h044, 32'h0, 4'h0, rd, er, n);
    chk("b2b_r1", rd, 32'h12345678);
    chk("b2b_r1_cycles", n, 2);

    // penable without a SETUP phase is ignored
    psel = 3'b001; penable = 1'b1; paddr = 11'h010; pwrite = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      seen = seen | rdy[0];
      @(posedge pclk); #1;
    end
    psel = '0; penable = 1'b0;
    chk("no_setup_noresp", {31'd0, seen}, 0);

    // Reset during the completing ACCESS cycle: no write, pready drops
    psel = 3'b001; penable = 1'b0; paddr = 11'h010; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0; psel = '0; penable = 1'b0;
    @(negedge pclk);
    chk("rst_mid_pready", {31'd0, rdy[0]}, 0);
    @(posedge pclk); #1;
    xfer(0, 0, 11'h010, 32'h0, 4'h0, rd, er, n);
    chk("rst_mid_nowrite", rd, 32'hDEADBEEF);

    // WS=3 build: 5-cycle transfers, out-of-range index error
    xfer(1, 1, 11'h008, 32'h55AA55AA, 4'hF, rd, er, n);
    chk("ws3_wr_cycles", n, 5);
    xfer(1, 0, 11'h008, 32'h0, 4'h0, rd, er, n);
    chk("ws3_rd_cycles", n, 5);
    chk("ws3_rd_data", rd, 32'h55AA55AA);
    xfer(1, 0, 11'h400, 32'h0, 4'h0, rd, er, n);
    chk("oor_err", {31'd0, er}, 1);
    chk("oor_prdata", rd, 32'd0);
    chk("oor_cycles", n, 5);

    // WS=2 build: abort by dropping psel mid-ACCESS
    xfer(2, 1, 11'h030, 32'h0BADF00D, 4'hF, rd, er, n);
    chk("ws2_wr_cycles", n, 4);
    psel = 3'b100; penable = 1'b0; paddr = 11'h030; pwrite = 1'b1;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      seen = seen | rdy[2];
      @(posedge pclk); #1;
    end
    chk("abort_noresp", {31'd0, seen}, 0);
    xfer(2, 0, 11'h030, 32'h0, 4'h0, rd, er, n);
    chk("abort_oldval", rd, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
